// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared state enumeration and code constants for the decoder scan driver
package decoder_scan_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// rtl/scan_dwell_timer.sv - per-code dwell counter with latched limit and terminal-count flag
module scan_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] limit_i,
  output logic               tc_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] limit_q, limit_d;

  assign tc_o = (cnt_q == limit_q);

  // Wrapping to zero on terminal count keeps the counter within DWELL_W bits for an all-ones limit.
  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (load_i) begin
      limit_d = limit_i;
      cnt_d   = '0;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/decoder_scan_driver.sv
// rtl/decoder_scan_driver.sv - scans a 4-to-16 decoder select code up or down with a programmable dwell
module decoder_scan_driver
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  output logic               w,
  output logic               x,
  output logic               y,
  output logic               z,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic               busy,
  output logic               wrap_pulse,
  output logic               done
);

  scan_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              dir_q, dir_d;
  logic              one_shot_q, one_shot_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              load, tc, at_last;

  scan_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != RUN),
    .load_i  (load),
    .en_i    (state_q == RUN),
    .limit_i (dwell),
    .tc_o    (tc)
  );

  assign at_last = dir_q ? (code_q == '0) : (code_q == CODE_MAX);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    dir_d      = dir_q;
    one_shot_d = one_shot_q;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          load       = 1'b1;
          dir_d      = dir;
          one_shot_d = one_shot;
          code_d     = dir ? CODE_MAX : '0;
          state_d    = RUN;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tc && one_shot_q && at_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (tc) begin
            code_d = dir_q ? code_q - 1'b1 : code_q + 1'b1;
            wrap_d = at_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      dir_q      <= dir_d;
      one_shot_q <= one_shot_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
    end
  end

  assign code         = code_q;
  assign {w, x, y, z} = code_q;
  assign code_valid   = valid_q;
  assign busy         = busy_q;
  assign wrap_pulse   = wrap_q;
  assign done         = done_q;

endmodule

// File: doc/decoder_scan_driver.md
DECODER_SCAN_DRIVER -- requirements
Module: decoder_scan_driver

Interface
REQ-001 SHALL have parameter: DWELL_W, 8, width of the dwell-count input.
REQ-002 SHALL have port: clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  level sampled each cycle; begins a scan from IDLE.
REQ-005 SHALL have port: stop  in  1  aborts a running scan.
REQ-006 SHALL have port: dir  in  1  0 = count up, 1 = count down; latched at start.
REQ-007 SHALL have port: one_shot  in  1  1 = single 16-code pass, 0 = continuous wrap; latched at start.
REQ-008 SHALL have port: dwell  in  DWELL_W  cycles per code minus one; latched at start.
REQ-009 SHALL have ports: w, x, y, z  out  1 each  code bits 3, 2, 1, 0, feeding the 4-to-16 decoder select inputs directly.
REQ-010 SHALL have port: code  out  4  same value as {w,x,y,z}.
REQ-011 SHALL have port: code_valid  out  1  high while code is being actively scanned.
REQ-012 SHALL have port: busy  out  1  high in RUN.
REQ-013 SHALL have port: wrap_pulse  out  1  one-cycle pulse on continuous-mode wrap.
REQ-014 SHALL have port: done  out  1  one-cycle pulse on one-shot completion.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: start=1 and stop=0 SHALL latch dir/one_shot/dwell, load code=0 (dir=0) or 15 (dir=1), clear dwell counter, go RUN.
REQ-017 The cycle after start is sampled SHALL show code_valid=1, busy=1, code = start value (latency 1).
REQ-018 RUN: dwell counter SHALL increment each cycle; when it equals latched dwell it SHALL clear and code SHALL step by +1 (up) or -1 (down), so each code is held dwell+1 cycles.
REQ-019 Continuous mode: step from 15 (up) or 0 (down) SHALL wrap modulo 16 and assert wrap_pulse for the first cycle of the new code.
REQ-020 One-shot mode: at dwell terminal of last code (15 up, 0 down) FSM SHALL go DONE; code holds last value.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=0, code_valid=0, then go IDLE.
REQ-022 stop=1 in RUN SHALL go IDLE next cycle, holding code, code_valid=0, busy=0, no done/wrap pulse.
REQ-023 start and stop both high SHALL be treated as stop (stop wins); start in RUN or DONE SHALL be ignored.
REQ-024 Changes to dir/one_shot/dwell during RUN SHALL have no effect until the next start.
REQ-025 dwell=0 SHALL give one code per cycle; dwell=all-ones SHALL give 2^DWELL_W cycles per code without overflow.
REQ-026 In IDLE, code SHALL hold its last value; code_valid, busy, done, wrap_pulse SHALL be 0.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, code=0, dwell counter=0, all outputs 0, latched config cleared (dir=0, one_shot=0, dwell=0).
REQ-028 reset SHALL override start/stop in the same cycle and abort RUN/DONE mid-operation with no done pulse.

Structure
REQ-029 Shared package decoder_scan_pkg SHALL hold the state enumeration (IDLE, RUN, DONE), CODE_W=4, CODE_MAX=15.
REQ-030 The dwell counter SHALL be a sub-module scan_dwell_timer (clear, load limit, terminal-count output); the FSM and code register remain in the top.

Verification
REQ-031 reset, then start with dir=0, one_shot=1, dwell=0 -> code 0..15 on 16 consecutive cycles, done=1 on the 17th, then IDLE with code=15.
REQ-032 start with dir=1, one_shot=0, dwell=2 -> code 15,14,...,0 each held 3 cycles, then 15 with wrap_pulse=1 for one cycle.
REQ-033 continuous up, dwell=0; stop at code=5 -> next cycle IDLE, code=5, busy=0, no done.
REQ-034 start and stop high together in IDLE -> remains IDLE; start pulsed in RUN -> scan unaffected.
REQ-035 change dwell from 1 to 7 mid-RUN -> code still steps every 2 cycles.
REQ-036 reset asserted at code=9 during one-shot RUN -> next cycle code=0, all outputs 0, no done pulse.
